mc_fifo: RTL and testbench

MC_FIFO -- requirements
Module: mc_fifo

---
 rtl/mc_fifo.sv | 104 ++++++++++
 tb/tb_mc_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mc_fifo.sv
// rtl/mc_fifo.sv - multi-channel FIFO with independent circular queues per channel
// Optional sticky overflow/underflow flags are enabled by defining MC_FIFO_ERR_FLAGS_EN.
module mc_fifo #(
   parameter int DATAW              = 64,
   parameter int DEPTH              = 16,
   parameter int NUM_CH             = 4,
   parameter int ALMOST_FULL_DEPTH  = 12,
   parameter int ALMOST_EMPTY_DEPTH = 2,
   localparam int ADDRW             = $clog2(DEPTH),
   localparam int CHW               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [CHW-1:0]              push_ch,
   input  logic [DATAW-1:0]            idata,
   input  logic [NUM_CH-1:0]           pop,
   input  logic                        err_clr,
   output logic [NUM_CH*DATAW-1:0]     odata,
   output logic [NUM_CH-1:0]           empty,
   output logic [NUM_CH-1:0]           full,
   output logic [NUM_CH-1:0]           almost_full,
   output logic [NUM_CH-1:0]           almost_empty,
   output logic [NUM_CH*(ADDRW+1)-1:0] count,
   output logic [NUM_CH-1:0]           overflow,
   output logic [NUM_CH-1:0]           underflow
);

   logic push_in_range;
   assign push_in_range = (32'(push_ch) < 32'(NUM_CH));

`ifndef MC_FIFO_ERR_FLAGS_EN
   logic unused_err_clr;
   assign unused_err_clr = err_clr;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATAW-1:0] mem [DEPTH];
      logic [ADDRW-1:0] head;
      logic [ADDRW-1:0] tail;
      logic [ADDRW:0]   cnt;
      logic             is_full;
      logic             is_empty;
      logic             push_sel;
      logic             do_push;
      logic             do_pop;

      // full/empty come from pre-edge state so a same-cycle pop never frees room for a push
      assign is_full  = (cnt == (ADDRW+1)'(DEPTH));
      assign is_empty = (cnt == '0);
      assign push_sel = push && push_in_range && (push_ch == CHW'(c));
      assign do_push  = push_sel && !is_full;
      assign do_pop   = pop[c] && !is_empty;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
         end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (!do_push && do_pop) cnt <= cnt - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (do_push && !rst) mem[tail] <= idata;
      end

      assign odata[c*DATAW +: DATAW]         = mem[head];
      assign count[c*(ADDRW+1) +: ADDRW+1]   = cnt;
      assign empty[c]                        = is_empty;
      assign full[c]                         = is_full;
      assign almost_full[c]                  = (32'(cnt) >= 32'(ALMOST_FULL_DEPTH));
      assign almost_empty[c]                 = (32'(cnt) <= 32'(ALMOST_EMPTY_DEPTH));

`ifdef MC_FIFO_ERR_FLAGS_EN
      logic ovf;
      logic udf;

      // a new error event takes priority over a clear in the same cycle
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
         end else begin
            if (push_sel && is_full) ovf <= 1'b1;
            else if (err_clr)        ovf <= 1'b0;
            if (pop[c] && is_empty)  udf <= 1'b1;
            else if (err_clr)        udf <= 1'b0;
         end
      end

      assign overflow[c]  = ovf;
      assign underflow[c] = udf;
`else
      assign overflow[c]  = 1'b0;
      assign underflow[c] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_mc_fifo.sv
// tb/tb_mc_fifo.sv - self-checking bench for mc_fifo with a queue-based reference model
module tb_mc_fifo;
   localparam int DW = 64;
   localparam int NC = 4;
   localparam int AW = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            push = 1'b0;
   logic [1:0]      push_ch = '0;
   logic [DW-1:0]   idata = '0;
   logic [NC-1:0]   pop = '0;
   logic            err_clr = 1'b0;
   logic [NC*DW-1:0] odata;
   logic [NC-1:0]   empty, full, almost_full, almost_empty, overflow, underflow;
   logic [NC*(AW+1)-1:0] count;

   int checks = 0;
   int failures = 0;

   mc_fifo dut (
      .clk(clk), .rst(rst), .push(push), .push_ch(push_ch), .idata(idata),
      .pop(pop), .err_clr(err_clr), .odata(odata), .empty(empty), .full(full),
      .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // reference model: one queue per channel plus sticky error bits
   logic [DW-1:0] q [NC][$];
   logic [NC-1:0] m_ov = '0;
   logic [NC-1:0] m_un = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NC; c++) q[c].delete();
         m_ov = '0;
         m_un = '0;
      end else begin
         int sz [NC];
         for (int c = 0; c < NC; c++) sz[c] = q[c].size();
         for (int c = 0; c < NC; c++) begin
            if (pop[c] && sz[c] > 0) void'(q[c].pop_front());
            if (pop[c] && sz[c] == 0) m_un[c] = 1'b1;
            else if (err_clr)         m_un[c] = 1'b0;
            if (push && int'(push_ch) == c && sz[c] == 16) m_ov[c] = 1'b1;
            else if (err_clr)                              m_ov[c] = 1'b0;
         end
         if (push && sz[push_ch] < 16) q[push_ch].push_back(idata);
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int c = 0; c < NC; c++) begin
            int n;
            logic eo, eu;
            n = q[c].size();
`ifdef MC_FIFO_ERR_FLAGS_EN
            eo = m_ov[c];
            eu = m_un[c];
`else
            eo = 1'b0;
            eu = 1'b0;
`endif
            chk($sformatf("count[%0d]", c), 64'(count[c*(AW+1) +: AW+1]), 64'(n));
            chk($sformatf("empty[%0d]", c), 64'(empty[c]), 64'(n == 0));
            chk($sformatf("full[%0d]", c), 64'(full[c]), 64'(n == 16));
            chk($sformatf("almost_full[%0d]", c), 64'(almost_full[c]), 64'(n >= 12));
            chk($sformatf("almost_empty[%0d]", c), 64'(almost_empty[c]), 64'(n <= 2));
            chk($sformatf("overflow[%0d]", c), 64'(overflow[c]), 64'(eo));
            chk($sformatf("underflow[%0d]", c), 64'(underflow[c]), 64'(eu));
            if (n > 0) chk($sformatf("odata[%0d]", c), odata[c*DW +: DW], q[c][0]);
         end
      end
   end

   task automatic step(input logic p, input logic [1:0] ch, input logic [DW-1:0] d,
                       input logic [NC-1:0] pp, input logic clr = 1'b0);
      push = p; push_ch = ch; idata = d; pop = pp; err_clr = clr;
      @(posedge clk);
      #1;
      push = 1'b0; pop = '0; err_clr = 1'b0;
   endtask

   function automatic logic [AW:0] cnt_of(input int c);
      return count[c*(AW+1) +: AW+1];
   endfunction

   initial begin
      #1;
      chk("reset_empty", 64'(empty), 64'hF);
      chk("reset_almost_empty", 64'(almost_empty), 64'hF);
      chk("reset_full", 64'(full), 64'h0);
      chk("reset_count", 64'(count), 64'h0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // three words into ch1
      step(1, 1, 64'hA1, 0);
      step(1, 1, 64'hA2, 0);
      step(1, 1, 64'hA3, 0);
      chk("ch1_count3", 64'(cnt_of(1)), 64'd3);
      chk("ch1_head", odata[1*DW +: DW], 64'hA1);
      chk("others_empty", 64'(empty), 64'b1101);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0010);

      // fill ch0, overflow attempt, drain in order
      for (int i = 0; i < 16; i++) step(1, 0, 64'h100 + 64'(i), 0);
      step(1, 0, 64'hDEAD, 0);
      chk("ch0_full", 64'(full[0]), 64'd1);
      chk("ch0_count16", 64'(cnt_of(0)), 64'd16);
`ifdef MC_FIFO_ERR_FLAGS_EN
      chk("ch0_overflow", 64'(overflow[0]), 64'd1);
`endif
      for (int i = 0; i < 16; i++) begin
         chk("ch0_drain_order", odata[DW-1:0], 64'h100 + 64'(i));
         step(0, 0, 0, 4'b0001);
      end
      chk("ch0_empty_after_drain", 64'(empty[0]), 64'd1);
      step(0, 0, 0, 0, 1'b1);

      // same-cycle push+pop on full then on empty channel
      for (int i = 0; i < 16; i++) step(1, 0, 64'h200 + 64'(i), 0);
      step(1, 0, 64'hBEEF, 4'b0001);
      chk("full_pushpop_count", 64'(cnt_of(0)), 64'd15);
      chk("full_pushpop_head", odata[DW-1:0], 64'h201);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 4'b0001);
      step(1, 0, 64'h77, 4'b0001);
      chk("empty_pushpop_count", 64'(cnt_of(0)), 64'd1);
      chk("empty_pushpop_data", odata[DW-1:0], 64'h77);
`ifdef MC_FIFO_ERR_FLAGS_EN
      chk("ch0_underflow", 64'(underflow[0]), 64'd1);
`endif
      step(0, 0, 0, 0, 1'b1);
      chk("err_cleared", 64'({overflow, underflow}), 64'h0);
      step(0, 0, 0, 4'b0001);

      // ch2 wrap-around and almost thresholds
      for (int i = 0; i < 14; i++) begin
         step(1, 2, 64'h300 + 64'(i), 0);
         if (i == 1)  chk("ae_at_2", 64'(almost_empty[2]), 64'd1);
         if (i == 2)  chk("ae_off_at_3", 64'(almost_empty[2]), 64'd0);
         if (i == 10) chk("af_off_at_11", 64'(almost_full[2]), 64'd0);
         if (i == 11) chk("af_at_12", 64'(almost_full[2]), 64'd1);
      end
      for (int i = 14; i < 26; i++) step(1, 2, 64'h300 + 64'(i), 4'b0100);
      for (int i = 0; i < 14; i++) begin
         chk("ch2_order", odata[2*DW +: DW], 64'h30C + 64'(i));
         step(0, 0, 0, 4'b0100);
      end

      // asynchronous reset mid-burst
      for (int i = 0; i < 7; i++) step(1, 0, 64'h400 + 64'(i), 0);
      chk("pre_reset_count7", 64'(cnt_of(0)), 64'd7);
      #1 rst = 1'b1;
      #1;
      chk("async_reset_count", 64'(cnt_of(0)), 64'd0);
      chk("async_reset_empty", 64'(empty[0]), 64'd1);
      #4 rst = 1'b0;
      @(posedge clk);
      #1;
      step(1, 0, 64'h55, 0);
      chk("post_reset_data", odata[DW-1:0], 64'h55);
      step(0, 0, 0, 4'b0001);
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
